// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, speed codes and default timing constants for the game tick sequencer
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_RELOAD = 2'd3
    } state_e;

    localparam logic [2:0] SPEED_L0 = 3'b000;
    localparam logic [2:0] SPEED_L1 = 3'b100;
    localparam logic [2:0] SPEED_L2 = 3'b010;
    localparam logic [2:0] SPEED_L3 = 3'b001;

    localparam int DEF_TICKS_PER_LEVEL = 32;
    localparam int DEF_RELOAD_CYCLES   = 2;

    function automatic logic [2:0] speed_of(input logic [1:0] lvl);
        return lvl == 2'd0 ? SPEED_L0 :
               lvl == 2'd1 ? SPEED_L1 :
               lvl == 2'd2 ? SPEED_L2 : SPEED_L3;
    endfunction

endpackage

// File: rtl/game_clk_sync.sv
// game_clk_sync: brings the asynchronous game clock into the in_clk domain and flags every transition
module game_clk_sync (
    input  logic in_clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic s1_q, s2_q, prev_q;

    // two synchronizer stages plus a previous-value flop for the transition compare
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= async_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign edge_pulse = s2_q ^ prev_q;

endmodule

// File: rtl/game_tick_sequencer.sv
// game_tick_sequencer: counts game clock transitions into ticks, steps levels and drives the divider controls
module game_tick_sequencer
    import game_pkg::*;
#(
    parameter int TICKS_PER_LEVEL = DEF_TICKS_PER_LEVEL,
    parameter int RELOAD_CYCLES   = DEF_RELOAD_CYCLES
) (
    input  logic        in_clk,
    input  logic        rst_n,
    input  logic        game_clk,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    output logic        enable_out,
    output logic [2:0]  speed_out,
    output logic        tick,
    output logic [1:0]  level,
    output logic [15:0] tick_count,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [1:0]  level_q, level_d;
    logic [15:0] lvl_cnt_q, lvl_cnt_d;
    logic [15:0] tick_count_q, tick_count_d;
    logic [3:0]  rl_cnt_q, rl_cnt_d;
    logic        tick_q, tick_d;
    logic        raw_tick, acc, wrap, lvl_up, rl_done;
    logic [15:0] cnt_inc;

    game_clk_sync u_sync (
        .in_clk    (in_clk),
        .rst_n     (rst_n),
        .async_in  (game_clk),
        .edge_pulse(raw_tick)
    );

    // a raw tick only counts in RUN and only when neither stop nor pause claims the cycle
    assign acc     = (state_q == ST_RUN) && raw_tick && !stop && !pause;
    assign cnt_inc = lvl_cnt_q + 16'd1;
    assign wrap    = cnt_inc == 16'(TICKS_PER_LEVEL);
    assign lvl_up  = acc && wrap && (level_q != 2'd3);
    assign rl_done = rl_cnt_q == 4'(RELOAD_CYCLES - 1);

    // state and datapath registers
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            level_q      <= 2'd0;
            lvl_cnt_q    <= 16'd0;
            tick_count_q <= 16'd0;
            rl_cnt_q     <= 4'd0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            lvl_cnt_q    <= lvl_cnt_d;
            tick_count_q <= tick_count_d;
            rl_cnt_q     <= rl_cnt_d;
            tick_q       <= tick_d;
        end
    end

    // next state: stop beats pause beats level-up beats start
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = (start && !pause) ? ST_RUN : ST_IDLE;
                ST_RUN:    state_d = pause ? ST_PAUSE : lvl_up ? ST_RELOAD : ST_RUN;
                ST_RELOAD: state_d = pause ? ST_PAUSE : rl_done ? ST_RUN : ST_RELOAD;
                ST_PAUSE:  state_d = pause ? ST_PAUSE : ST_RUN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // counters: cleared in IDLE or on stop, advanced on accepted ticks; reload count restarts on every entry
    always_comb begin
        level_d      = level_q;
        lvl_cnt_d    = lvl_cnt_q;
        tick_count_d = tick_count_q;
        tick_d       = acc;
        if (stop || state_q == ST_IDLE) begin
            level_d      = 2'd0;
            lvl_cnt_d    = 16'd0;
            tick_count_d = 16'd0;
        end else if (acc) begin
            tick_count_d = tick_count_q + 16'd1;
            lvl_cnt_d    = wrap ? 16'd0 : cnt_inc;
            level_d      = lvl_up ? level_q + 2'd1 : level_q;
        end
        rl_cnt_d = (state_q == ST_RELOAD && state_d == ST_RELOAD) ? rl_cnt_q + 4'd1 : 4'd0;
    end

    // outputs decoded from the current state and registered datapath
    always_comb begin
        enable_out = state_q == ST_RUN;
        busy       = state_q != ST_IDLE;
        speed_out  = speed_of(level_q);
        level      = level_q;
        tick       = tick_q;
        tick_count = tick_count_q;
    end

endmodule

// File: tb/tb_game_tick_sequencer.sv
// tb_game_tick_sequencer: directed checks of tick latency, level stepping, reload, pause, stop and async reset
module tb_game_tick_sequencer;

    logic        in_clk = 1'b0;
    logic        rst_n, game_clk, start, pause, stop;
    logic        enable_out, tick, busy;
    logic [2:0]  speed_out;
    logic [1:0]  level;
    logic [15:0] tick_count;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 in_clk = ~in_clk;

    game_tick_sequencer #(.TICKS_PER_LEVEL(4), .RELOAD_CYCLES(2)) dut (
        .in_clk    (in_clk),
        .rst_n     (rst_n),
        .game_clk  (game_clk),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .enable_out(enable_out),
        .speed_out (speed_out),
        .tick      (tick),
        .level     (level),
        .tick_count(tick_count),
        .busy      (busy)
    );

    task automatic step(input int n);
        repeat (n) @(posedge in_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"},    32'(enable_out), 32'd0);
        chk({tag, "_speed"}, 32'(speed_out),  32'd0);
        chk({tag, "_tick"},  32'(tick),       32'd0);
        chk({tag, "_level"}, 32'(level),      32'd0);
        chk({tag, "_count"}, 32'(tick_count), 32'd0);
        chk({tag, "_busy"},  32'(busy),       32'd0);
    endtask

    // toggle game_clk and check the pulse lands exactly 3 cycles later; leaves time just after that edge
    task automatic tog(input string tag, input logic exp_tick, input logic [15:0] exp_cnt);
        game_clk = ~game_clk;
        step(2);
        chk({tag, "_early"}, 32'(tick), 32'd0);
        step(1);
        chk({tag, "_tick"},  32'(tick), 32'(exp_tick));
        chk({tag, "_count"}, 32'(tick_count), 32'(exp_cnt));
    endtask

    initial begin
        rst_n = 1'b0; game_clk = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        step(3);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        step(2);
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        step(1);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_en", 32'(enable_out), 32'd1);
        step(16);
        for (int i = 1; i <= 3; i++) begin
            tog($sformatf("t%0d", i), 1'b1, 16'(i));
            step(1);
            chk($sformatf("t%0d_off", i), 32'(tick), 32'd0);
            chk($sformatf("t%0d_en", i), 32'(enable_out), 32'd1);
            step(16);
        end
        tog("t4", 1'b1, 16'd4);
        chk("t4_level", 32'(level), 32'd1);
        chk("t4_speed", 32'(speed_out), 32'b100);
        chk("t4_rl0", 32'(enable_out), 32'd0);
        step(1);
        chk("t4_rl1", 32'(enable_out), 32'd0);
        chk("t4_off", 32'(tick), 32'd0);
        step(1);
        chk("t4_back", 32'(enable_out), 32'd1);
        step(15);
        for (int i = 5; i <= 17; i++) begin
            tog($sformatf("t%0d", i), 1'b1, 16'(i));
            if (i == 8) begin
                chk("t8_level", 32'(level), 32'd2);
                chk("t8_speed", 32'(speed_out), 32'b010);
            end
            if (i == 12) begin
                chk("t12_level", 32'(level), 32'd3);
                chk("t12_speed", 32'(speed_out), 32'b001);
                chk("t12_rl", 32'(enable_out), 32'd0);
            end
            if (i == 16 || i == 17) begin
                chk($sformatf("t%0d_level", i), 32'(level), 32'd3);
                chk($sformatf("t%0d_norl", i), 32'(enable_out), 32'd1);
            end
            step(17);
        end
        chk("sat_speed", 32'(speed_out), 32'b001);
        pause = 1'b1;
        step(1);
        chk("pause_en", 32'(enable_out), 32'd0);
        chk("pause_busy", 32'(busy), 32'd1);
        step(16);
        for (int i = 1; i <= 3; i++) begin
            tog($sformatf("p%0d", i), 1'b0, 16'd17);
            step(1);
            chk($sformatf("p%0d_off", i), 32'(tick), 32'd0);
            step(16);
        end
        pause = 1'b0;
        step(1);
        chk("resume_en", 32'(enable_out), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk($sformatf("resume_nostale%0d", i), 32'(tick), 32'd0);
        end
        chk("resume_count", 32'(tick_count), 32'd17);
        step(14);
        tog("t18", 1'b1, 16'd18);
        step(17);
        stop = 1'b1;
        step(1);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_count", 32'(tick_count), 32'd0);
        chk("stop_level", 32'(level), 32'd0);
        step(1);
        chk("stop_start_idle", 32'(busy), 32'd0);
        stop = 1'b0;
        step(1);
        chk("restart_busy", 32'(busy), 32'd1);
        step(16);
        for (int i = 1; i <= 6; i++) begin
            tog($sformatf("s%0d", i), 1'b1, 16'(i));
            step(17);
        end
        game_clk = ~game_clk;
        step(2);
        stop = 1'b1;
        step(1);
        chk("stoptick_tick", 32'(tick), 32'd0);
        chk("stoptick_count", 32'(tick_count), 32'd0);
        chk("stoptick_level", 32'(level), 32'd0);
        chk("stoptick_busy", 32'(busy), 32'd0);
        stop = 1'b0;
        step(1);
        chk("rerun_busy", 32'(busy), 32'd1);
        step(16);
        for (int i = 1; i <= 3; i++) begin
            tog($sformatf("r%0d", i), 1'b1, 16'(i));
            step(17);
        end
        tog("r4", 1'b1, 16'd4);
        chk("r4_rl", 32'(enable_out), 32'd0);
        chk("r4_level", 32'(level), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        step(2);
        chk_reset_outputs("held_rst");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/game_tick_sequencer.md
GAME_TICK_SEQUENCER -- requirements
Module: game_tick_sequencer

Interface
REQ-001 The module SHALL have parameter TICKS_PER_LEVEL, default 32, giving the counted ticks per level-up (range 2..65535).
REQ-002 The module SHALL have parameter RELOAD_CYCLES, default 2, giving the cycles enable_out is held low on a level-up (range 1..15).
REQ-003 The module SHALL have port in_clk, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port game_clk, input, 1 bit: the toggling game clock from the divider, treated as asynchronous.
REQ-006 The module SHALL have port start, input, 1 bit: level signal that moves IDLE to RUN.
REQ-007 The module SHALL have port pause, input, 1 bit: level signal that holds the game while high.
REQ-008 The module SHALL have port stop, input, 1 bit: returns the block to IDLE and clears progress.
REQ-009 The module SHALL have port enable_out, output, 1 bit: drives the divider enable; low forces the divider to reload.
REQ-010 The module SHALL have port speed_out, output, 3 bits: one-hot speed select to the divider, or 3'b000 for the slowest speed.
REQ-011 The module SHALL have port tick, output, 1 bit: one-cycle game-step pulse.
REQ-012 The module SHALL have port level, output, 2 bits: current level, 0..3.
REQ-013 The module SHALL have port tick_count, output, 16 bits: total counted ticks since the last IDLE.
REQ-014 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 game_clk SHALL pass through a 2-flop synchronizer followed by a registered previous-value flop; any transition (rise or fall) of the synchronized value SHALL be one raw tick.
REQ-016 Latency from a game_clk transition to the tick pulse SHALL be 3 in_clk cycles; tick SHALL be high for exactly 1 cycle per transition.
REQ-017 The FSM SHALL have states IDLE, RUN, PAUSE and RELOAD.
REQ-018 IDLE behaviour: enable_out=0, level=0, tick_count=0, per-level counter=0; move to RUN when start=1.
REQ-019 RUN behaviour: enable_out=1; each raw tick asserts tick, increments tick_count (wrapping 16'hFFFF to 0) and increments the per-level counter.
REQ-020 In RUN, when the per-level counter reaches TICKS_PER_LEVEL and level<3: level SHALL increment, the counter SHALL clear, and the FSM SHALL move to RELOAD in the same cycle.
REQ-021 At level 3 the counter SHALL clear on reaching TICKS_PER_LEVEL, with no level change and no RELOAD.
REQ-022 RELOAD behaviour: enable_out=0 for exactly RELOAD_CYCLES cycles, then return to RUN; speed_out SHALL already show the new level during the first RELOAD cycle.
REQ-023 PAUSE behaviour: entered from RUN or RELOAD while pause=1; enable_out=0; return to RUN when pause=0, discarding any unfinished RELOAD count.
REQ-024 Speed mapping SHALL be: level0 = 3'b000, level1 = 3'b100, level2 = 3'b010, level3 = 3'b001.
REQ-025 Raw ticks occurring in IDLE, PAUSE or RELOAD SHALL be discarded: no tick pulse and no count change. The edge detector SHALL keep tracking so no stale tick appears on resume.
REQ-026 Priority within a cycle SHALL be stop > pause > level-up > start.
REQ-027 stop=1 from any state SHALL reach IDLE on the next edge and clear the counters, even if a tick occurs in the same cycle.
REQ-028 A tick coinciding with pause=1 in RUN SHALL be discarded.
REQ-029 start held high in IDLE together with stop=1 SHALL leave the block in IDLE.

Reset
REQ-030 On rst_n=0 (asynchronous) the block SHALL go to IDLE with all synchronizer flops 0, enable_out=0, speed_out=3'b000, tick=0, level=0, tick_count=0 and busy=0.
REQ-031 Reset asserted mid-RUN or mid-RELOAD SHALL take effect immediately, with no partial tick pulse.

Structure
REQ-032 Package game_pkg SHALL hold the state enum, the four speed codes and the default TICKS_PER_LEVEL/RELOAD_CYCLES constants.
REQ-033 Sub-module game_clk_sync SHALL hold the 2-flop synchronizer and the transition detector (in_clk, rst_n, async_in, edge_pulse).

Verification (TICKS_PER_LEVEL=4, RELOAD_CYCLES=2)
REQ-034 Bench: reset, start=1, toggle game_clk every 20 cycles -> tick pulses 3 cycles after each toggle; tick_count reaches 3 after 3 toggles; enable_out=1.
REQ-035 Bench: 4th tick -> level=1, speed_out=3'b100, enable_out=0 for exactly 2 cycles, then 1.
REQ-036 Bench: 16 ticks -> level saturates at 3, speed_out=3'b001; further ticks produce no RELOAD.
REQ-037 Bench: pause=1 for 3 toggles, then pause=0 -> no tick pulses during pause, tick_count unchanged, no extra pulse on resume.
REQ-038 Bench: stop=1 in the same cycle as a tick at tick_count=7 -> IDLE, tick_count=0, level=0, no tick pulse.
REQ-039 Bench: rst_n=0 during RELOAD -> all outputs return to their reset values immediately, before the next in_clk edge.
